// File: rtl/dataram_store_buffer.sv
// In-order store FIFO in front of the 256x8 data RAM write port.
// Optional STORE_FWD_EN adds combinational store-to-load forwarding (LdAddr/FwdHit/FwdData).
module dataram_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       StValid,
    output logic                       StReady,
    input  logic [AW-1:0]              StAddr,
    input  logic [DW-1:0]              StData,
    output logic                       MemWrite,
    output logic [AW-1:0]              MemAddr,
    output logic [DW-1:0]              MemData,
    input  logic                       MemReady,
    output logic                       Empty,
`ifdef STORE_FWD_EN
    input  logic [AW-1:0]              LdAddr,
    output logic                       FwdHit,
    output logic [DW-1:0]              FwdData,
`endif
    output logic [$clog2(DEPTH+1)-1:0] Count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cnt;
    logic          push, pop;

    // Full rejects even when the head pops this cycle, so StReady never sees MemReady.
    assign StReady  = (cnt != CW'(DEPTH));
    assign Empty    = (cnt == '0);
    assign MemWrite = !Empty;
    assign push     = StValid && StReady;
    assign pop      = MemWrite && MemReady;
    assign Count    = cnt;

    // Zero when empty so unreset storage never leaks X onto the RAM bus.
    assign MemAddr  = Empty ? '0 : addr_q[rd_ptr];
    assign MemData  = Empty ? '0 : data_q[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[wr_ptr] <= StAddr;
            data_q[wr_ptr] <= StData;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef STORE_FWD_EN
    // Walk oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        FwdHit  = 1'b0;
        FwdData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < cnt) && (addr_q[idx] == LdAddr)) begin
                FwdHit  = 1'b1;
                FwdData = data_q[idx];
            end
        end
    end
`endif
endmodule

// File: tb/tb_dataram_store_buffer.sv
// Scoreboard bench for dataram_store_buffer: stores queued on acceptance, checked on RAM pop.
module tb_dataram_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          StValid = 1'b0;
    logic          StReady;
    logic [AW-1:0] StAddr = '0;
    logic [DW-1:0] StData = '0;
    logic          MemWrite;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemData;
    logic          MemReady = 1'b0;
    logic          Empty;
    logic [CW-1:0] Count;
`ifdef STORE_FWD_EN
    logic [AW-1:0] LdAddr = '0;
    logic          FwdHit;
    logic [DW-1:0] FwdData;
`endif

    dataram_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .StValid(StValid), .StReady(StReady), .StAddr(StAddr), .StData(StData),
        .MemWrite(MemWrite), .MemAddr(MemAddr), .MemData(MemData), .MemReady(MemReady),
        .Empty(Empty),
`ifdef STORE_FWD_EN
        .LdAddr(LdAddr), .FwdHit(FwdHit), .FwdData(FwdData),
`endif
        .Count(Count)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;
    logic [AW+DW-1:0] sb [$];
    logic [DW-1:0] ref_ram [256] = '{default: 8'h00};
    logic [DW-1:0] dut_ram [256] = '{default: 8'h00};
    logic          hold_v = 1'b0;
    logic [AW+DW:0] hold_val = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int cyc = 0;
        StValid  = 1'b0;
        MemReady = 1'b1;
        while (!Empty && cyc < 20) begin
            step();
            cyc++;
        end
        chk("drain", {31'b0, Empty}, 1);
    endtask

    // Inputs settle 1 time unit after posedge; everything sampled here is what the next edge sees.
    always @(negedge CLK) begin
        if (!RST_N) begin
            sb.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("hold", {15'b0, MemWrite, MemAddr, MemData}, {15'b0, hold_val});
            hold_v   = MemWrite && !MemReady;
            hold_val = {MemWrite, MemAddr, MemData};
        end
        if (MemWrite && MemReady) begin
            chk("pop_pending", {31'b0, sb.size() != 0}, 1);
            if (sb.size() != 0) chk("mem_wr", {16'b0, MemAddr, MemData}, {16'b0, sb.pop_front()});
            n_wr++;
            dut_ram[MemAddr] = MemData;
        end
        if (RST_N && StValid && StReady) begin
            sb.push_back({StAddr, StData});
            ref_ram[StAddr] = StData;
        end
    end

    initial begin
        int w0;
        int cyc;
        #12;
        chk("rst_count", 32'(Count), 0);
        chk("rst_empty", {31'b0, Empty}, 1);
        chk("rst_memwrite", {31'b0, MemWrite}, 0);
        chk("rst_stready", {31'b0, StReady}, 1);
        chk("rst_memaddr", {24'b0, MemAddr}, 0);
        chk("rst_memdata", {24'b0, MemData}, 0);
        RST_N = 1'b1;
        step();

        // single store: no bypass, one cycle on the bus, then empty
        StValid = 1'b1; StAddr = 8'h10; StData = 8'h5A; MemReady = 1'b1;
        chk("no_bypass", {31'b0, MemWrite}, 0);
        step();
        StValid = 1'b0;
        chk("single_wr", {31'b0, MemWrite}, 1);
        chk("single_addr", {24'b0, MemAddr}, 32'h10);
        chk("single_data", {24'b0, MemData}, 32'h5A);
        chk("single_cnt", 32'(Count), 1);
        step();
        chk("single_empty", {31'b0, Empty}, 1);
        chk("single_idle", {31'b0, MemWrite}, 0);

        // fill, hold 5th store, then drain in order
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            StValid = 1'b1; StAddr = 8'(8'h30 + i); StData = 8'(8'hA0 + i);
            step();
        end
        chk("full_cnt", 32'(Count), 4);
        chk("full_rdy", {31'b0, StReady}, 0);
        StAddr = 8'h34; StData = 8'hA4;
        step(); step();
        chk("full_hold_cnt", 32'(Count), 4);
        chk("full_head", {24'b0, MemAddr}, 32'h30);
        MemReady = 1'b1;
        step();
        chk("full_no_push", 32'(Count), 3);
        step();
        StValid = 1'b0;
        chk("full_pushpop", 32'(Count), 3);
        cyc = 0;
        while (!Empty && cyc < 20) begin
            step();
            cyc++;
        end
        chk("drain_cycles", cyc, 3);

        // simultaneous push/pop with pointer wrap
        MemReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            StValid = 1'b1; StAddr = 8'(8'h50 + i); StData = 8'(8'hC0 + i);
            step();
        end
        StValid = 1'b0;
        chk("sim_cnt0", 32'(Count), 2);
        MemReady = 1'b1;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            StValid = 1'b1; StAddr = 8'(8'h60 + i); StData = 8'(3 * i + 1);
            step();
            chk("sim_cnt", 32'(Count), 2);
        end
        drain();

        // reset mid-drain with three pending
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            StValid = 1'b1; StAddr = 8'(8'h70 + i); StData = 8'(8'hE0 + i);
            step();
        end
        StValid = 1'b0;
        MemReady = 1'b1;
        step();
        chk("pre_rst_cnt", 32'(Count), 3);
        #1;
        RST_N = 1'b0;
        w0 = n_wr;
        #1;
        chk("mid_rst_cnt", 32'(Count), 0);
        chk("mid_rst_empty", {31'b0, Empty}, 1);
        chk("mid_rst_wr", {31'b0, MemWrite}, 0);
        step(); step(); step();
        chk("rst_no_wr", n_wr, w0);
        RST_N = 1'b1;
        step();
        chk("post_rst_empty", {31'b0, Empty}, 1);
        chk("post_rst_cnt", 32'(Count), 0);

        // random backpressure against a reference RAM
        StValid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!(StValid && !StReady)) begin
                StValid = 1'($urandom_range(0, 1));
                StAddr  = 8'(8'h80 + $urandom_range(0, 15));
                StData  = 8'($urandom);
            end
            MemReady = 1'($urandom_range(0, 1));
            step();
        end
        drain();
        for (int a = 8'h80; a < 8'h90; a++) chk("ram", {24'b0, dut_ram[a]}, {24'b0, ref_ram[a]});
        chk("sb_empty", sb.size(), 0);

`ifdef STORE_FWD_EN
        MemReady = 1'b0;
        StValid = 1'b1; StAddr = 8'h20; StData = 8'h11;
        step();
        StData = 8'h22;
        step();
        StAddr = 8'h30; StData = 8'h33;
        step();
        StValid = 1'b0;
        LdAddr = 8'h20;
        #1;
        chk("fwd_hit", {31'b0, FwdHit}, 1);
        chk("fwd_data", {24'b0, FwdData}, 32'h22);
        LdAddr = 8'h21;
        #1;
        chk("fwd_miss", {31'b0, FwdHit}, 0);
        chk("fwd_miss_data", {24'b0, FwdData}, 0);
        drain();
        LdAddr = 8'h20;
        #1;
        chk("fwd_empty", {31'b0, FwdHit}, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
